// File: rtl/aes_bram_responder_if.sv
// ============================================================================
// Module   : aes_bram_responder_if
// Brief    : AES request handshake plus BRAM port bundle for the responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_bram_responder_if #(
  parameter int ADDR_BITS = 12
);
  logic                 aes_start_read;
  logic [31:0]          aes_bram_addr;
  logic                 aes_start_write;
  logic [31:0]          aes_bram_write_addr;
  logic [31:0]          aes_bram_write_data;
  logic [31:0]          aes_bram_read_data;
  logic                 bram_complete;
  logic                 bram_en;
  logic [3:0]           bram_we;
  logic [ADDR_BITS-1:0] bram_addr;
  logic [31:0]          bram_din;
  logic [31:0]          bram_dout;

  // Responder side: consumes requests and BRAM read data, drives the BRAM port.
  modport slave (
    input  aes_start_read, aes_bram_addr, aes_start_write,
           aes_bram_write_addr, aes_bram_write_data, bram_dout,
    output aes_bram_read_data, bram_complete, bram_en, bram_we,
           bram_addr, bram_din
  );

  modport master (
    output aes_start_read, aes_bram_addr, aes_start_write,
           aes_bram_write_addr, aes_bram_write_data, bram_dout,
    input  aes_bram_read_data, bram_complete, bram_en, bram_we,
           bram_addr, bram_din
  );
endinterface

`default_nettype wire

// File: rtl/aes_bram_responder.sv
// ============================================================================
// Module   : aes_bram_responder
// Brief    : Serves single-word AES read/write requests on one BRAM port.
//            Optional AES_BRAM_BOUNDS_CHECK_EN rejects out-of-window addresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_bram_responder #(
  parameter int          ADDR_BITS    = 12,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  wire logic           aes_clk,
  input  wire logic           aes_rst_n,
`ifdef AES_BRAM_BOUNDS_CHECK_EN
  output logic                bram_addr_err,
`endif
  aes_bram_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_DONE     = 3'd4,
    S_RELEASE  = 3'd5
  } state_t;

  localparam logic [1:0] C_LAT_LOAD = 2'(READ_LATENCY - 1);

  state_t               r_state;
  logic                 r_is_read;
  logic [1:0]           r_cnt;
  logic [31:0]          r_read_data;
  logic                 r_complete;
  logic                 r_bram_en;
  logic [3:0]           r_bram_we;
  logic [ADDR_BITS-1:0] r_bram_addr;
  logic [31:0]          r_bram_din;

  logic [31:0]          w_req_addr;
  logic [31:0]          w_offset;
  logic [ADDR_BITS-1:0] w_word;
  logic                 w_served_start;
  logic                 w_oob;
  logic                 w_unused_offset;

  // Read wins a tie, so the address under test follows the same priority.
  assign w_req_addr      = bus.aes_start_read ? bus.aes_bram_addr : bus.aes_bram_write_addr;
  assign w_offset        = w_req_addr - BASE_ADDR;
  assign w_word          = w_offset[ADDR_BITS+1:2];
  assign w_unused_offset = &{1'b0, w_offset[31:ADDR_BITS+2], w_offset[1:0]};
  assign w_served_start  = r_is_read ? bus.aes_start_read : bus.aes_start_write;

`ifdef AES_BRAM_BOUNDS_CHECK_EN
  localparam logic [32:0] C_LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_BITS);
  logic r_addr_err;
  assign w_oob         = (w_req_addr < BASE_ADDR) || ({1'b0, w_req_addr} >= C_LIMIT);
  assign bram_addr_err = r_addr_err;
`else
  assign w_oob = 1'b0;
`endif

  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      r_state     <= S_IDLE;
      r_is_read   <= 1'b0;
      r_cnt       <= 2'd0;
      r_read_data <= 32'd0;
      r_complete  <= 1'b0;
      r_bram_en   <= 1'b0;
      r_bram_we   <= 4'd0;
      r_bram_addr <= '0;
      r_bram_din  <= 32'd0;
`ifdef AES_BRAM_BOUNDS_CHECK_EN
      r_addr_err  <= 1'b0;
`endif
    end else begin
      r_complete <= 1'b0;
      r_bram_en  <= 1'b0;
      r_bram_we  <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (bus.aes_start_read || bus.aes_start_write) begin
            r_is_read   <= bus.aes_start_read;
            r_bram_addr <= w_word;
            if (w_oob) begin
              if (bus.aes_start_read) r_read_data <= 32'hDEAD_BEEF;
`ifdef AES_BRAM_BOUNDS_CHECK_EN
              r_addr_err <= 1'b1;
`endif
              r_state <= S_DONE;
            end else if (bus.aes_start_read) begin
              r_bram_en <= 1'b1;
              r_state   <= S_RD_ISSUE;
            end else begin
              r_bram_en  <= 1'b1;
              r_bram_we  <= 4'hF;
              r_bram_din <= bus.aes_bram_write_data;
              r_state    <= S_WR_ISSUE;
            end
          end
        end
        S_RD_ISSUE: begin
          r_cnt   <= C_LAT_LOAD;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_read_data <= bus.bram_dout;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_WR_ISSUE: r_state <= S_DONE;
        S_DONE: begin
          r_complete <= 1'b1;
          r_state    <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!w_served_start) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.aes_bram_read_data = r_read_data;
  assign bus.bram_complete      = r_complete;
  assign bus.bram_en            = r_bram_en;
  assign bus.bram_we            = r_bram_we;
  assign bus.bram_addr          = r_bram_addr;
  assign bus.bram_din           = r_bram_din;

endmodule

`default_nettype wire

// File: tb/tb_aes_bram_responder.sv
// ============================================================================
// Module   : tb_aes_bram_responder
// Brief    : Self-checking bench: directed table, corner sequences, random requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_bram_responder;
  localparam int RL    = 2;
  localparam int DEPTH = 4096;

  logic aes_clk;
  logic aes_rst_n;
`ifdef AES_BRAM_BOUNDS_CHECK_EN
  logic bram_addr_err;
`endif

  aes_bram_responder_if #(.ADDR_BITS(12)) bus ();

  aes_bram_responder #(
    .ADDR_BITS   (12),
    .READ_LATENCY(RL),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .aes_clk      (aes_clk),
    .aes_rst_n    (aes_rst_n),
`ifdef AES_BRAM_BOUNDS_CHECK_EN
    .bram_addr_err(bram_addr_err),
`endif
    .bus          (bus)
  );

  initial aes_clk = 1'b0;
  always #5 aes_clk = ~aes_clk;

  // Synchronous BRAM with a two-stage read pipeline.
  logic [31:0] bram_mem [DEPTH];
  logic [31:0] rd_pipe0, rd_pipe1;
  always @(posedge aes_clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we == 4'hF) bram_mem[bus.bram_addr] <= bus.bram_din;
      rd_pipe0 <= bram_mem[bus.bram_addr];
    end
    rd_pipe1 <= rd_pipe0;
  end
  assign bus.bram_dout = rd_pipe1;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_read;
  int n_err    = 0;
  int n_checks = 0;

  typedef struct {
    bit          rd;
    bit          drop;
    logic [31:0] addr;
    logic [31:0] wd;
    int          word;
    logic [31:0] exp_data;
    int          lat;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request from the requester's point of view; inputs change on negedges.
  task automatic run_req(input bit rd, input bit drop, input logic [31:0] addr,
                         input logic [31:0] wd, input int word,
                         input logic [31:0] exp_data, input int exp_lat);
    int lat = -1;
    int en_cnt = 0;
    logic [31:0] en_addr = 'x;
    logic [31:0] en_we   = 'x;
    logic [31:0] en_din  = 'x;
    if (rd) begin
      bus.aes_start_read = 1'b1; bus.aes_bram_addr = addr;
    end else begin
      bus.aes_start_write = 1'b1; bus.aes_bram_write_addr = addr; bus.aes_bram_write_data = wd;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge aes_clk);
      if (drop && k == 0) begin
        bus.aes_start_read = 1'b0; bus.aes_start_write = 1'b0;
      end
      if (bus.bram_en) begin
        en_cnt++; en_addr = 32'(bus.bram_addr); en_we = 32'(bus.bram_we); en_din = bus.bram_din;
      end
      if (bus.bram_complete) begin
        lat = k;
        break;
      end
    end
    chk(rd ? "rd_latency" : "wr_latency", 32'(lat), 32'(exp_lat));
    chk("en_pulses", 32'(en_cnt), 32'd1);
    chk("bram_addr", en_addr, 32'(word));
    chk("bram_we", en_we, rd ? 32'd0 : 32'hF);
    if (!rd) chk("bram_din", en_din, wd);
    chk("read_data", bus.aes_bram_read_data, exp_data);
    bus.aes_start_read  = 1'b0;
    bus.aes_start_write = 1'b0;
    @(negedge aes_clk);
    chk("complete_pulse_width", 32'(bus.bram_complete), 32'd0);
    if (rd) last_read = exp_data;
    else    ref_mem[word] = wd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k1, k2, wr_seen, cnt;
    logic [31:0] a, d;
    bit r;

    for (int i = 0; i < DEPTH; i++) begin
      bram_mem[i] <= 32'(i) * 32'h9E37_79B9;
      ref_mem[i]   = 32'(i) * 32'h9E37_79B9;
    end
    for (int i = 0; i < 4; i++) begin
      bram_mem[i] <= 32'hA0A0_0000 + 32'(i);
      ref_mem[i]   = 32'hA0A0_0000 + 32'(i);
    end
    bram_mem[4] <= 32'h0123_4567;
    ref_mem[4]   = 32'h0123_4567;

    tbl[0]  = '{1, 0, 32'h0000_0010, 32'h0,         4,    32'h0123_4567, RL + 2};
    tbl[1]  = '{0, 0, 32'h0000_0020, 32'hCAFE_F00D, 8,    32'h0123_4567, 2};
    tbl[2]  = '{1, 0, 32'h0000_0020, 32'h0,         8,    32'hCAFE_F00D, RL + 2};
    tbl[3]  = '{1, 0, 32'h0000_0000, 32'h0,         0,    32'hA0A0_0000, RL + 2};
    tbl[4]  = '{1, 0, 32'h0000_0004, 32'h0,         1,    32'hA0A0_0001, RL + 2};
    tbl[5]  = '{1, 0, 32'h0000_0008, 32'h0,         2,    32'hA0A0_0002, RL + 2};
    tbl[6]  = '{1, 0, 32'h0000_000C, 32'h0,         3,    32'hA0A0_0003, RL + 2};
    tbl[7]  = '{1, 0, 32'h0000_0023, 32'h0,         8,    32'hCAFE_F00D, RL + 2};
    tbl[8]  = '{0, 0, 32'h0000_4004, 32'h1357_9BDF, 1,    32'hCAFE_F00D, 2};
    tbl[9]  = '{1, 0, 32'h0000_0004, 32'h0,         1,    32'h1357_9BDF, RL + 2};
    tbl[10] = '{1, 1, 32'h0000_000C, 32'h0,         3,    32'hA0A0_0003, RL + 2};
    tbl[11] = '{0, 0, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 4095, 32'hA0A0_0003, 2};
    tbl[12] = '{1, 0, 32'h0000_3FFC, 32'h0,         4095, 32'h0BAD_CAFE, RL + 2};
    tbl[13] = '{0, 1, 32'h0000_0040, 32'h1111_2222, 16,   32'h0BAD_CAFE, 2};

    bus.aes_start_read = 1'b0; bus.aes_start_write = 1'b0;
    bus.aes_bram_addr = '0; bus.aes_bram_write_addr = '0; bus.aes_bram_write_data = '0;
    aes_rst_n = 1'b0;
    last_read = 32'd0;
    repeat (2) @(negedge aes_clk);
    chk("reset_read_data", bus.aes_bram_read_data, 32'd0);
    chk("reset_complete",  32'(bus.bram_complete), 32'd0);
    chk("reset_en",        32'(bus.bram_en), 32'd0);
    chk("reset_we",        32'(bus.bram_we), 32'd0);
    chk("reset_addr",      32'(bus.bram_addr), 32'd0);
    chk("reset_din",       bus.bram_din, 32'd0);
    aes_rst_n = 1'b1;
    @(negedge aes_clk);

    for (int i = 0; i < 14; i++)
      run_req(tbl[i].rd, tbl[i].drop, tbl[i].addr, tbl[i].wd, tbl[i].word,
              tbl[i].exp_data, tbl[i].lat);

    // Read and write raised together: read first, write after the read releases.
    bus.aes_start_read = 1'b1; bus.aes_bram_addr = 32'h4;
    bus.aes_start_write = 1'b1; bus.aes_bram_write_addr = 32'h30; bus.aes_bram_write_data = 32'h7777_0001;
    k1 = -1; k2 = -1; wr_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge aes_clk);
      if (bus.bram_en && bus.bram_we == 4'hF && bus.bram_addr == 12'd12 && bus.bram_din == 32'h7777_0001)
        wr_seen++;
      if (bus.bram_complete) begin
        if (k1 < 0) begin
          k1 = k;
          chk("tie_read_data", bus.aes_bram_read_data, ref_mem[1]);
          bus.aes_start_read = 1'b0;
        end else begin
          k2 = k;
          break;
        end
      end
    end
    chk("tie_read_latency", 32'(k1), 32'(RL + 2));
    chk("tie_write_latency", 32'(k2), 32'(RL + 2 + 4));
    chk("tie_write_issued", 32'(wr_seen), 32'd1);
    bus.aes_start_write = 1'b0;
    ref_mem[12] = 32'h7777_0001;
    last_read = ref_mem[1];
    @(negedge aes_clk);
    run_req(1, 0, 32'h30, 0, 12, 32'h7777_0001, RL + 2);

    // Reset while the read is waiting on BRAM data.
    bus.aes_start_read = 1'b1; bus.aes_bram_addr = 32'h10;
    repeat (2) @(negedge aes_clk);
    aes_rst_n = 1'b0;
    bus.aes_start_read = 1'b0;
    #1;
    chk("midrst_en", 32'(bus.bram_en), 32'd0);
    chk("midrst_we", 32'(bus.bram_we), 32'd0);
    chk("midrst_read_data", bus.aes_bram_read_data, 32'd0);
    chk("midrst_addr", 32'(bus.bram_addr), 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge aes_clk);
      if (bus.bram_complete) cnt++;
    end
    aes_rst_n = 1'b1;
    repeat (3) begin
      @(negedge aes_clk);
      if (bus.bram_complete) cnt++;
    end
    chk("midrst_no_complete", 32'(cnt), 32'd0);
    last_read = 32'd0;
    run_req(1, 0, 32'h10, 0, 4, 32'h0123_4567, RL + 2);

    // Random traffic against the memory model; bit 14 exercises address wrap.
    for (int n = 0; n < 40; n++) begin
      int w;
      r = 1'($urandom_range(0, 1));
      a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3))
          | (32'($urandom_range(0, 1)) << 14);
      d = $urandom;
      w = int'((a >> 2) % 32'(DEPTH));
      run_req(r, 1'($urandom_range(0, 3) == 0), a, d, w,
              r ? ref_mem[w] : last_read, r ? RL + 2 : 2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
